// File: rtl/p4_parte1_mem_pkg.sv
// Shared definitions for the memory tester: controller state encoding,
// data width, default geometry and the LFSR feedback constant.
package p4_parte1_mem_pkg;

  localparam int unsigned DATA_W        = 16;
  localparam int unsigned DEFAULT_DEPTH = 512;
  localparam int unsigned DEFAULT_AW    = 9;

  // Galois feedback taps used when MEM_TESTER_LFSR_EN is defined.
  localparam logic [DATA_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StReadReq,
    StReadWait,
    StDone
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] value);
    return (value == '1) ? value : value + DATA_W'(1);
  endfunction

endpackage

// File: rtl/p4_parte1_mem_tester_if.sv
// Avalon-MM master bus between the memory tester and the memory under test.
//   master : avm_address, avm_byteenable, avm_write, avm_read, avm_writedata out;
//            avm_waitrequest, avm_readdata, avm_readdatavalid in
//   slave  : the mirror image
// AW is the word-address width; the byte address is AW+1 bits wide.
interface p4_parte1_mem_tester_if #(
  parameter int unsigned AW = 9
) ();
  import p4_parte1_mem_pkg::*;

  logic [AW:0]       avm_address;
  logic [1:0]        avm_byteenable;
  logic              avm_write;
  logic              avm_read;
  logic [DATA_W-1:0] avm_writedata;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;

  modport master (
    output avm_address, avm_byteenable, avm_write, avm_read, avm_writedata,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_byteenable, avm_write, avm_read, avm_writedata,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );

endinterface

// File: rtl/p4_parte1_pattern_gen.sv
// Test pattern generator shared by the fill and verify phases.
//   clk, reset_n : clock, asynchronous active-low reset (word clears to 0)
//   load         : restart the sequence at load_value
//   load_value   : seed for the sequence
//   step         : advance to the next word (load has priority)
//   word         : current pattern word (registered)
// Build option: MEM_TESTER_LFSR_EN selects a 16-bit Galois LFSR (a zero seed is
// replaced by 1); otherwise the pattern increments by one per word.
module p4_parte1_pattern_gen
  import p4_parte1_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_value,
  input  logic              step,
  output logic [DATA_W-1:0] word
);

  logic [DATA_W-1:0] word_q, word_d;

`ifdef MEM_TESTER_LFSR_EN
  logic [DATA_W-1:0] seed_eff;

  // An all-zero LFSR state would lock up.
  assign seed_eff = (load_value == '0) ? DATA_W'(1) : load_value;

  always_comb begin
    word_d = word_q;
    if (load) begin
      word_d = seed_eff;
    end else if (step) begin
      word_d = (word_q >> 1) ^ (word_q[0] ? LFSR_TAPS : '0);
    end
  end
`else
  always_comb begin
    word_d = word_q;
    if (load) begin
      word_d = load_value;
    end else if (step) begin
      word_d = word_q + DATA_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word = word_q;

endmodule

// File: rtl/p4_parte1_mem_tester.sv
// Memory tester: fills DEPTH 16-bit words over an Avalon-MM master with a
// seeded pattern, reads them back one at a time and counts mismatches.
//   clk, reset_n   : clock, asynchronous active-low reset
//   start, seed    : one-cycle start pulse (accepted only when idle), pattern seed
//   avm            : Avalon-MM master bus (p4_parte1_mem_tester_if.master)
//   busy, done     : pass in progress, one-cycle end-of-pass pulse
//   pass           : last pass had zero mismatches (held until next start)
//   err_count      : saturating mismatch count
//   first_err_addr : word address of the first mismatch, 0 if none
// Build option: MEM_TESTER_LFSR_EN (see p4_parte1_pattern_gen).
module p4_parte1_mem_tester
  import p4_parte1_mem_pkg::*;
#(
  parameter int unsigned       DEPTH = DEFAULT_DEPTH,
  parameter int unsigned       AW    = DEFAULT_AW,
  parameter logic [DATA_W-1:0] SEED  = 16'h0001
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     seed,
  p4_parte1_mem_tester_if.master avm,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [DATA_W-1:0]     err_count,
  output logic [AW-1:0]         first_err_addr
);

  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  state_e            state_q;
  logic [AW-1:0]     index_q;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] err_q;
  logic [AW-1:0]     first_q;
  logic              wr_q, rd_q, busy_q, done_q, pass_q;

  logic              last, wr_accept, rd_accept, rd_valid, mismatch;
  logic [DATA_W-1:0] err_next;
  logic              gen_load, gen_step;
  logic [DATA_W-1:0] gen_load_value, pattern;

  p4_parte1_pattern_gen u_pattern_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (gen_load),
    .load_value (gen_load_value),
    .step       (gen_step),
    .word       (pattern)
  );

  always_comb begin
    last      = (index_q == LastIdx);
    wr_accept = (state_q == StWrite) && !avm.avm_waitrequest;
    rd_accept = (state_q == StReadReq) && !avm.avm_waitrequest;
    // Data may arrive in the same cycle the read is accepted.
    rd_valid  = avm.avm_readdatavalid && (rd_accept || (state_q == StReadWait));
    mismatch  = rd_valid && (avm.avm_readdata != pattern);
    err_next  = mismatch ? sat_inc(err_q) : err_q;
    // Restart the generator on start and again for the verify phase.
    gen_load       = ((state_q == StIdle) && start) || (wr_accept && last);
    gen_load_value = (state_q == StIdle) ? seed : seed_q;
    gen_step       = (wr_accept || rd_valid) && !last;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      index_q <= '0;
      seed_q  <= SEED;
      err_q   <= '0;
      first_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            seed_q  <= seed;
            err_q   <= '0;
            first_q <= '0;
            pass_q  <= 1'b0;
            index_q <= '0;
            busy_q  <= 1'b1;
            wr_q    <= 1'b1;
            state_q <= StWrite;
          end
        end
        StWrite: begin
          if (wr_accept) begin
            if (last) begin
              index_q <= '0;
              wr_q    <= 1'b0;
              rd_q    <= 1'b1;
              state_q <= StReadReq;
            end else begin
              index_q <= index_q + AW'(1);
            end
          end
        end
        StReadReq, StReadWait: begin
          if (rd_valid) begin
            err_q <= err_next;
            if (mismatch && (err_q == '0)) begin
              first_q <= index_q;
            end
            if (last) begin
              rd_q    <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_next == '0);
              state_q <= StDone;
            end else begin
              index_q <= index_q + AW'(1);
              rd_q    <= 1'b1;
              state_q <= StReadReq;
            end
          end else if (rd_accept) begin
            rd_q    <= 1'b0;
            state_q <= StReadWait;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign avm.avm_address    = {index_q, 1'b0};
  assign avm.avm_byteenable = 2'b11;
  assign avm.avm_write      = wr_q;
  assign avm.avm_read       = rd_q;
  assign avm.avm_writedata  = pattern;

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;

endmodule

// File: tb/tb_p4_parte1_mem_tester.sv
// Bench for p4_parte1_mem_tester: behavioural memory with optional random
// waitrequest, read latency 0 or 1 and injectable read corruption.
module tb_p4_parte1_mem_tester;
  import p4_parte1_mem_pkg::*;

  localparam int unsigned DEPTH  = 512;
  localparam int unsigned AW     = 9;
  localparam int          BUDGET = 20000;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [15:0]       seed = '0;
  logic              busy, done, pass;
  logic [15:0]       err_count;
  logic [AW-1:0]     first_err_addr;

  int checks = 0;
  int errors = 0;

  p4_parte1_mem_tester_if #(.AW(AW)) avm_if ();

  p4_parte1_mem_tester #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .SEED  (16'h0001)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .seed           (seed),
    .avm            (avm_if),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

  always #5 clk = ~clk;

  // Memory model and bus monitor
  logic [15:0]      mem [DEPTH];
  logic [15:0]      exp_mem [DEPTH];
  logic [DEPTH-1:0] corrupt_mask = '0;
  logic             wait_en = 1'b0;
  logic             lat0 = 1'b0;
  logic             wait_q = 1'b0;
  logic             mon_clr = 1'b1;
  logic             rdv_q = 1'b0;
  logic [15:0]      rdata_q = '0;
  logic [AW-1:0]    rd_idx;
  int               wr_cnt, rd_cnt, viol, done_cnt;
  logic             hold_pend;
  logic [AW:0]      hold_addr;
  logic             hold_wr, hold_rd;
  logic [15:0]      hold_data;
  logic             bad;

  assign rd_idx = avm_if.avm_address[AW:1];
  assign avm_if.avm_waitrequest   = wait_q;
  assign avm_if.avm_readdatavalid = lat0 ? (avm_if.avm_read && !wait_q) : rdv_q;
  assign avm_if.avm_readdata      = lat0 ? (mem[rd_idx] ^ {12'b0, corrupt_mask[rd_idx], 3'b0})
                                         : rdata_q;

  always @(negedge clk) wait_q = wait_en ? 1'($urandom_range(0, 1)) : 1'b0;

  always_comb begin
    bad = 1'b0;
    if (avm_if.avm_write && avm_if.avm_read) bad = 1'b1;
    if ((avm_if.avm_write || avm_if.avm_read) && avm_if.avm_byteenable != 2'b11) bad = 1'b1;
    if (hold_pend && (avm_if.avm_write != hold_wr || avm_if.avm_read != hold_rd ||
                      avm_if.avm_address != hold_addr ||
                      (hold_wr && avm_if.avm_writedata != hold_data))) bad = 1'b1;
    if (avm_if.avm_write && !wait_q && avm_if.avm_address != {AW'(wr_cnt), 1'b0}) bad = 1'b1;
    if (avm_if.avm_read && !wait_q && avm_if.avm_address != {AW'(rd_cnt), 1'b0}) bad = 1'b1;
  end

  always @(posedge clk) begin
    rdv_q <= 1'b0;
    if (mon_clr) begin
      wr_cnt    <= 0;
      rd_cnt    <= 0;
      viol      <= 0;
      done_cnt  <= 0;
      hold_pend <= 1'b0;
    end else begin
      viol      <= viol + int'(bad);
      hold_pend <= (avm_if.avm_write || avm_if.avm_read) && wait_q;
      hold_wr   <= avm_if.avm_write;
      hold_rd   <= avm_if.avm_read;
      hold_addr <= avm_if.avm_address;
      hold_data <= avm_if.avm_writedata;
      if (avm_if.avm_write && !wait_q) begin
        mem[avm_if.avm_address[AW:1]] <= avm_if.avm_writedata;
        wr_cnt <= wr_cnt + 1;
      end
      if (avm_if.avm_read && !wait_q) begin
        rd_cnt  <= rd_cnt + 1;
        rdv_q   <= !lat0;
        rdata_q <= mem[rd_idx] ^ {12'b0, corrupt_mask[rd_idx], 3'b0};
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Expected memory image from the pattern rule.
  task automatic build_expected(input logic [15:0] s);
`ifdef MEM_TESTER_LFSR_EN
    logic [15:0] v;
    v = (s == 16'h0) ? 16'h0001 : s;
    for (int i = 0; i < DEPTH; i++) begin
      exp_mem[i] = v;
      v = lfsr_next(v);
    end
`else
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = s + 16'(i);
`endif
  endtask

  task automatic check_outputs_reset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_first"}, first_err_addr, 0);
    check({tag, "_wr"}, avm_if.avm_write, 0);
    check({tag, "_rd"}, avm_if.avm_read, 0);
    check({tag, "_addr"}, avm_if.avm_address, 0);
    check({tag, "_wdata"}, avm_if.avm_writedata, 0);
  endtask

  // One full pass; spurious=1 re-pulses start while busy.
  task automatic run_pass(input logic [15:0] s, input bit we, input bit l0,
                          input bit spurious, output int lat);
    int n_err, first, mem_bad;
    @(negedge clk);
    wait_en = we;
    lat0    = l0;
    mon_clr = 1'b1;
    build_expected(s);
    @(negedge clk);
    mon_clr = 1'b0;
    seed    = s;
    start   = 1'b1;
    lat     = 0;
    while (lat < BUDGET) begin
      @(posedge clk);
      #1;
      lat++;
      seed = 16'($urandom);
      if (done) break;
      start = spurious && ($urandom_range(0, 7) == 0);
    end
    start = 1'b0;
    check("done_seen", done, 1);
    check("busy_at_done", busy, 0);
    n_err = 0;
    first = 0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (corrupt_mask[i]) begin
        n_err++;
        first = i;
      end
    end
    check("pass", pass, (n_err == 0) ? 1 : 0);
    check("err_count", err_count, n_err);
    check("first_err_addr", first_err_addr, first);
    @(posedge clk);
    #1;
    check("done_width", done, 0);
    repeat (5) @(posedge clk);
    #1;
    check("stay_idle", busy, 0);
    check("done_count", done_cnt, 1);
    check("write_count", wr_cnt, DEPTH);
    check("read_count", rd_cnt, DEPTH);
    check("protocol", viol, 0);
    mem_bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) mem_bad++;
    check("mem_contents", mem_bad, 0);
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_reset("por");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_busy", busy, 0);

    // Zero waitstates, read latency 1: word image, latency, clean pass.
`ifdef MEM_TESTER_LFSR_EN
    run_pass(16'h0000, 1'b0, 1'b0, 1'b0, lat);
    check("lfsr_word0", mem[0], 16'h0001);
    check("lfsr_word1", mem[1], 16'hB400);
`else
    run_pass(16'h0001, 1'b0, 1'b0, 1'b0, lat);
    check("word5", mem[5], 16'h0006);
`endif
    check("latency", lat, 3 * DEPTH + 1);

    // Corrupted read of word 17 (bit 3).
    corrupt_mask = '0;
    corrupt_mask[17] = 1'b1;
    run_pass(16'h1234, 1'b0, 1'b0, 1'b0, lat);
    corrupt_mask = '0;

    // Random waitrequest, latency 1 then latency 0, with starts while busy.
    run_pass(16'hBEEF, 1'b1, 1'b0, 1'b1, lat);
    run_pass(16'hFFF0, 1'b1, 1'b1, 1'b1, lat);
    run_pass(16'h0007, 1'b0, 1'b1, 1'b0, lat);
    check("latency_lat0", lat, 2 * DEPTH + 1);

    // Randomised passes with a few corrupted words.
    for (int p = 0; p < 5; p++) begin
      corrupt_mask = '0;
      for (int k = $urandom_range(0, 3); k > 0; k--) corrupt_mask[$urandom_range(0, DEPTH - 1)] = 1'b1;
      run_pass(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, lat);
    end
    corrupt_mask = '0;

    // Short reset pulse mid-verify, with a read response still in flight.
    @(negedge clk);
    wait_en = 1'b0;
    lat0    = 1'b0;
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
    seed    = 16'h00A5;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (699) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs_reset("midreset");
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("midreset_no_done", done_cnt, 0);
    check("midreset_idle", busy, 0);
    run_pass(16'h5A5A, 1'b1, 1'b0, 1'b0, lat);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/p4_parte1_mem_tester.md
P4_PARTE1_MEM_TESTER -- requirements
Module: p4_parte1_mem_tester

Interface
REQ-001 Parameter DEPTH, default 512, number of 16-bit words tested (power of two, 2..512).
REQ-002 Parameter AW, default 9, word-address width (log2 DEPTH).
REQ-003 Parameter SEED, default 16'h0001, reset value of the pattern seed register.
REQ-004 Port list, one per line: name, direction, width, meaning.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse; begins a fill+verify pass when idle.
REQ-008 seed  in  16  pattern seed, sampled on accepted start.
REQ-009 avm_address  out  AW+1  byte address; bit 0 always 0.
REQ-010 avm_byteenable  out  2  always 2'b11.
REQ-011 avm_write / avm_read  out  1 each  Avalon-MM commands, never both high.
REQ-012 avm_writedata  out  16  pattern word.
REQ-013 avm_waitrequest  in  1  holds the current command.
REQ-014 avm_readdata  in  16  read response data.
REQ-015 avm_readdatavalid  in  1  qualifies avm_readdata.
REQ-016 busy  out  1  high from accepted start until done.
REQ-017 done  out  1  one-cycle pulse at end of pass.
REQ-018 pass  out  1  high after a pass with zero mismatches; held until next start.
REQ-019 err_count  out  16  mismatch count, saturating at 16'hFFFF.
REQ-020 first_err_addr  out  AW  word address of first mismatch; 0 if none.

Function
REQ-021 States: IDLE, WRITE, READ_REQ, READ_WAIT, DONE.
REQ-022 IDLE: start -> latch seed, clear err_count/first_err_addr/pass, index=0, go WRITE; start ignored in any other state.
REQ-023 WRITE: avm_write=1, address=index<<1, writedata=pattern(index); advance index only on cycle with avm_waitrequest=0; after index DEPTH-1 accepted, index=0, go READ_REQ.
REQ-024 READ_REQ: avm_read=1 held until avm_waitrequest=0, then go READ_WAIT; one outstanding read maximum.
REQ-025 READ_WAIT: on avm_readdatavalid compare avm_readdata to pattern(index); mismatch increments err_count (saturating) and records first_err_addr if it is the first; then index+1 and READ_REQ, or DONE after index DEPTH-1.
REQ-026 readdatavalid arriving in the same cycle as read acceptance is legal and SHALL be consumed as in READ_WAIT (READ_WAIT skipped).
REQ-027 DONE: done=1 for one cycle, pass=(err_count==0), busy=0, return IDLE.
REQ-028 Index arithmetic AW bits; terminal detection by compare to DEPTH-1, never by wrap.
REQ-029 Default pattern(i) = seed_q + i, modulo 2^16.
REQ-030 Fill-to-done latency with zero waitstates and read latency 1: 3*DEPTH+1 cycles from start.

Reset
REQ-031 reset_n low SHALL asynchronously force IDLE, avm_write=avm_read=0, busy=done=pass=0, err_count=0, first_err_addr=0, avm_address=0, avm_writedata=0.
REQ-032 Reset mid-pass abandons the pass; no done pulse; an in-flight readdatavalid after release is ignored in IDLE.

Configuration
REQ-033 Macro MEM_TESTER_LFSR_EN defined: pattern is a 16-bit Galois LFSR (taps 16'hB400) stepped once per word, starting at seed_q (seed 0 replaced by 1), restarted at seed_q for the read phase.
REQ-034 Macro undefined: incrementing pattern per REQ-029; no LFSR logic synthesised.

Structure
REQ-035 Shared package p4_parte1_mem_pkg holds the state enum, DATA_W=16, default DEPTH/AW, and LFSR tap constant.
REQ-036 One sub-module p4_parte1_pattern_gen (seed load, step, current word) serves both phases.

Verification
REQ-037 Zero-waitstate 512x16 memory model, seed=16'h0001, no macro -> word 5 holds 16'h0006, done at cycle 1537, pass=1, err_count=0.
REQ-038 Model corrupts read of word 17 (bit 3 flipped) -> err_count=1, first_err_addr=17, pass=0.
REQ-039 Random waitrequest (50%) on writes and reads -> same memory contents and pass=1; no command dropped or duplicated.
REQ-040 reset_n pulled low at cycle 700 -> all outputs at reset values within same cycle, no done; new start afterwards passes.
REQ-041 MEM_TESTER_LFSR_EN, seed=0 -> word 0 written 16'h0001, word 1 16'hB400, pass=1.
REQ-042 start pulsed while busy -> ignored; exactly one done pulse per accepted start.
